// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU/memory types: word, RAM handshake state and the
//               memory arbiter grant state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DBUSY = 2'd1,
        IBUSY = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
// Module      : memory_arbiter
// Description : Serialises the instruction and data ports onto one
//               single-ported RAM, with fetch starvation guard and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        memerr
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
    localparam logic [3:0] c_starve_max   = 4'hF;
    localparam logic [7:0] c_tcnt_last    = 8'(TIMEOUT - 1);

    arb_state_t state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       memerr_q, memerr_d;
    logic       w_dreq;
    logic       w_greq;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
            tcnt_q   <= 8'd0;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tcnt_q   <= tcnt_d;
            memerr_q <= memerr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        tcnt_d   = tcnt_q + 8'd1;
        memerr_d = memerr_q;
        w_dreq   = dREN | dWEN;
        w_greq   = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'd0;
        dload    = 32'd0;

        case (state_q)
            IDLE: begin
                tcnt_d = 8'd0;
                if (!iREN) begin
                    starve_d = 4'd0;
                end
                // A fetch only wins when data has had its quota of grants.
                if (w_dreq && ((starve_q < c_starve_limit) || !iREN)) begin
                    state_d = DBUSY;
                end else if (iREN) begin
                    state_d = IBUSY;
                end
            end
            DBUSY: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramstore = dstore;
                w_greq   = w_dreq;
                if (w_greq && (ramstate == ACCESS)) begin
                    dwait = 1'b0;
                    dload = ramload;
                    if (iREN && (starve_q != c_starve_max)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            IBUSY: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                w_greq  = iREN;
                if (w_greq && (ramstate == ACCESS)) begin
                    iwait    = 1'b0;
                    iload    = ramload;
                    starve_d = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every busy exit returns through IDLE for the turnaround cycle.
        if (state_q != IDLE) begin
            if (!w_greq) begin
                state_d = IDLE;
            end else if (ramstate == ACCESS) begin
                state_d = IDLE;
            end else if (ramstate == ERROR) begin
                memerr_d = 1'b1;
                state_d  = IDLE;
            end else if (tcnt_q == c_tcnt_last) begin
                memerr_d = 1'b1;
                state_d  = IDLE;
            end
        end
    end

    assign memerr = memerr_q;

endmodule

`default_nettype wire
